// File: rtl/mmio_out_fifo.sv
// Memory-mapped output FIFO: the processor pushes words at offset 0, a valid/ready consumer drains them.
// Optional interrupt output is enabled by defining MMIO_OUT_FIFO_IRQ_EN.
module mmio_out_fifo #(
    parameter logic [3:0]  BASE_HI    = 4'h3,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] rd_data,
    output logic [15:0] out_data,
    output logic        out_valid,
`ifdef MMIO_OUT_FIFO_IRQ_EN
    output logic        irq,
`endif
    input  logic        out_ready
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   head_d;
    logic [15:0]   status;
    logic [15:0]   rd_next;
    logic          irq_en_q, irq_en_d;

    // Bus decode; ADDR[11:2] ignored so the block aliases across its 4K window.
    logic       sel;
    logic [1:0] offset;
    logic       wr_data, wr_ctrl;
    logic       flush, clr_ovf;
    logic       full, empty;
    logic       push, pop, ovf_set;

    assign sel     = (ADDR[15:12] == BASE_HI);
    assign offset  = ADDR[1:0];
    assign wr_data = W & sel & (offset == 2'd0);
    assign wr_ctrl = W & sel & (offset == 2'd2);
    assign flush   = wr_ctrl & DOUT[0];
    assign clr_ovf = wr_ctrl & DOUT[1];

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);

    // Fullness is judged on the pre-edge count; a same-edge pop does not make room.
    assign push    = wr_data & ~full;
    assign ovf_set = wr_data & full;
    assign pop     = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

`ifdef MMIO_OUT_FIFO_IRQ_EN
    assign irq_en_d = wr_ctrl ? DOUT[2] : irq_en_q;
`else
    assign irq_en_d = 1'b0;
`endif

    // Next head word; bypass the memory when the word being pushed becomes the head.
    always_comb begin
        head_d = mem[rd_ptr_d];
        if (push && (wr_ptr_q == rd_ptr_d)) head_d = DOUT;
    end

    always_comb begin
        status                 = '0;
        status[15]             = ovf_q;
        status[14]             = full;
        status[13]             = empty;
        status[12]             = irq_en_q;
        status[DEPTH_LOG2:0]   = count_q;
    end

    always_comb begin
        rd_next = '0;
        if (sel) begin
            case (offset)
                2'd0:    rd_next = out_valid ? out_data : 16'h0000;
                2'd1:    rd_next = status;
                default: rd_next = 16'h0000;
            endcase
        end
    end

    // Storage is not reset; flush only rewinds the pointers.
    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr_q] <= DOUT;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            rd_data   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            out_valid <= (count_d != '0);
            out_data  <= head_d;
            rd_data   <= rd_next;
        end
    end

`ifdef MMIO_OUT_FIFO_IRQ_EN
    always_ff @(posedge Clock) begin
        if (!Resetn) irq <= 1'b0;
        else         irq <= irq_en_d & ((count_d == '0) | ovf_d);
    end
`endif

endmodule

// File: tb/tb_mmio_out_fifo.sv
// Directed bench for mmio_out_fifo at default parameters (DEPTH 8).
// Covers the irq port too when MMIO_OUT_FIFO_IRQ_EN is defined.
module tb_mmio_out_fifo;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef MMIO_OUT_FIFO_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    mmio_out_fifo dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .ADDR      (ADDR),
        .DOUT      (DOUT),
        .W         (W),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef MMIO_OUT_FIFO_IRQ_EN
        .irq       (irq),
`endif
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DOUT = d;
        W    = 1'b1;
        tick();
        W    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        ADDR = a;
        W    = 1'b0;
        tick();
        v = rd_data;
    endtask

    logic [15:0] v;

    initial begin
        Resetn    = 1'b0;
        ADDR      = 16'h3001;
        DOUT      = 16'h0000;
        W         = 1'b0;
        out_ready = 1'b0;
        tick(2);
        check("rst_rd_data", rd_data, 16'h0000);
        check("rst_valid", {15'd0, out_valid}, 16'h0000);
        Resetn = 1'b1;
        tick(2);
        check("rst_status", rd_data, 16'h2000);
        check("rst_valid2", {15'd0, out_valid}, 16'h0000);
        check("rst_out_data", out_data, 16'h0000);

        // Two words, no fall-through, then drain.
        bus_write(16'h3000, 16'hAAAA);
        check("push1_valid", {15'd0, out_valid}, 16'h0001);
        check("push1_data", out_data, 16'hAAAA);
        bus_write(16'h3000, 16'h5555);
        check("push2_head_stable", out_data, 16'hAAAA);
        bus_read(16'h3001, v);
        check("status_cnt2", v, 16'h0002);
        bus_read(16'h3000, v);
        check("data_read_head", v, 16'hAAAA);
        out_ready = 1'b1;
        tick();
        check("drain_2nd_data", out_data, 16'h5555);
        check("drain_2nd_valid", {15'd0, out_valid}, 16'h0001);
        tick();
        check("drain_empty", {15'd0, out_valid}, 16'h0000);
        out_ready = 1'b0;

        // Overflow: nine writes into depth 8.
        for (int i = 1; i <= 9; i++) bus_write(16'h3000, 16'(i));
        bus_read(16'h3001, v);
        check("status_full_ovf", v, 16'hC008);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain_valid", {15'd0, out_valid}, 16'h0001);
            check("ovf_drain_data", out_data, 16'(i));
            tick();
        end
        check("ovf_drained", {15'd0, out_valid}, 16'h0000);
        out_ready = 1'b0;
        bus_read(16'h3001, v);
        check("status_ovf_sticky", v, 16'hA000);
        bus_write(16'h3002, 16'h0002);
        bus_read(16'h3001, v);
        check("status_ovf_cleared", v, 16'h2000);

        // Full FIFO with simultaneous pop and push: push still dropped.
        for (int i = 0; i < 8; i++) bus_write(16'h3000, 16'h0010 + 16'(i));
        check("full_head", out_data, 16'h0010);
        out_ready = 1'b1;
        bus_write(16'h3000, 16'h0099);
        out_ready = 1'b0;
        check("full_pop_head", out_data, 16'h0011);
        bus_read(16'h3001, v);
        check("full_pop_status", v, 16'h8007);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("wrap_drain_data", out_data, 16'h0010 + 16'(i));
            tick();
        end
        check("wrap_drained", {15'd0, out_valid}, 16'h0000);
        out_ready = 1'b0;

        // Flush + clear overflow beats a simultaneous pop.
        for (int i = 1; i <= 3; i++) bus_write(16'h3000, 16'h0020 + 16'(i));
        ADDR      = 16'h3002;
        DOUT      = 16'h0003;
        W         = 1'b1;
        out_ready = 1'b1;
        tick();
        W = 1'b0;
        check("flush_valid", {15'd0, out_valid}, 16'h0000);
        tick(3);
        check("flush_no_more", {15'd0, out_valid}, 16'h0000);
        out_ready = 1'b0;
        bus_read(16'h3001, v);
        check("flush_status", v, 16'h2000);

        // Decode: foreign address, read-only status, aliasing, reserved offsets.
        bus_write(16'h1000, 16'hBEEF);
        bus_read(16'h3001, v);
        check("foreign_write_ignored", v, 16'h2000);
        bus_write(16'h3000, 16'h0077);
        bus_write(16'h3001, 16'hFFFF);
        bus_read(16'h3FF1, v);
        check("alias_status", v, 16'h0001);
        bus_read(16'h1001, v);
        check("unselected_zero", v, 16'h0000);
        bus_read(16'h3003, v);
        check("reserved_zero", v, 16'h0000);
        bus_read(16'h3002, v);
        check("control_read_zero", v, 16'h0000);
        bus_read(16'h3FFC, v);
        check("alias_data", v, 16'h0077);

        // Pop and push on the same edge with one word queued.
        out_ready = 1'b1;
        bus_write(16'h3000, 16'h0078);
        out_ready = 1'b0;
        check("popush_valid", {15'd0, out_valid}, 16'h0001);
        check("popush_data", out_data, 16'h0078);
        bus_read(16'h3001, v);
        check("popush_status", v, 16'h0001);

        // Reset mid-operation.
        bus_write(16'h3000, 16'h0079);
        Resetn = 1'b0;
        tick();
        check("midrst_valid", {15'd0, out_valid}, 16'h0000);
        check("midrst_data", out_data, 16'h0000);
        Resetn = 1'b1;
        tick();
        bus_read(16'h3001, v);
        check("midrst_status", v, 16'h2000);

`ifdef MMIO_OUT_FIFO_IRQ_EN
        check("irq_off", {15'd0, irq}, 16'h0000);
        bus_write(16'h3002, 16'h0004);
        check("irq_on_empty", {15'd0, irq}, 16'h0001);
        bus_read(16'h3001, v);
        check("irq_en_status", v, 16'h3000);
        bus_write(16'h3000, 16'h0005);
        check("irq_off_push", {15'd0, irq}, 16'h0000);
`else
        bus_write(16'h3002, 16'h0004);
        bus_read(16'h3001, v);
        check("no_irq_status", v, 16'h2000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
